// File: rtl/alu_pipe_n_if.sv
// Operand/result stream bundle for alu_pipe_n: upstream beat handshake,
// carry-clear strobe and downstream result handshake with status flags.
interface alu_pipe_n_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             carry_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             flag_c;
   logic             flag_z;
   logic             flag_n;
   logic             flag_v;

   modport master (
      output in_valid, a, b, op, carry_clr, out_ready,
      input  in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v
   );

   modport slave (
      input  in_valid, a, b, op, carry_clr, out_ready,
      output in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v
   );
endinterface

// File: rtl/alu_pipe_n.sv
// Two-stage valid/ready pipelined ALU: stage 1 captures operands, stage 2
// computes result/flags and keeps a persistent carry for ADC/SBB chaining.
module alu_pipe_n #(
   parameter int WIDTH = 16
) (
   input logic         clk,
   input logic         rst_n,
   alu_pipe_n_if.slave bus
);

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_XOR  = 3'b100,
      OP_ADC  = 3'b101,
      OP_SBB  = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   op_e              s1_op;

   logic             s2_valid;
   logic [WIDTH-1:0] res_q;
   logic             c_out_q;
   logic             z_out_q;
   logic             n_out_q;
   logic             v_out_q;
   logic             c_q;

   logic             adv2;
   logic             accept;
   logic             is_arith;
   logic             cin;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res_d;
   logic             c_d;
   logic             v_d;

   // Stage 1 may move forward whenever stage 2 is empty or is being drained,
   // so in_ready never looks at in_valid.
   assign adv2         = s1_valid & (~s2_valid | bus.out_ready);
   assign bus.in_ready = ~s1_valid | adv2;
   assign accept       = bus.in_valid & bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= OP_AND;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_a     <= bus.a;
         s1_b     <= bus.b;
         s1_op    <= op_e'(bus.op);
      end else if (adv2) begin
         s1_valid <= 1'b0;
      end
   end

   // Subtraction is a + ~b + cin, so b_eff is also the operand used for overflow.
   always_comb begin
      is_arith = 1'b0;
      cin      = 1'b0;
      b_eff    = s1_b;
      res_d    = s1_a;
      c_d      = 1'b0;
      v_d      = 1'b0;
      case (s1_op)
         OP_AND:  res_d = s1_a & s1_b;
         OP_OR:   res_d = s1_a | s1_b;
         OP_XOR:  res_d = s1_a ^ s1_b;
         OP_PASS: res_d = s1_a;
         OP_ADD:  is_arith = 1'b1;
         OP_ADC: begin
            is_arith = 1'b1;
            cin      = c_q;
         end
         OP_SUB: begin
            is_arith = 1'b1;
            b_eff    = ~s1_b;
            cin      = 1'b1;
         end
         OP_SBB: begin
            is_arith = 1'b1;
            b_eff    = ~s1_b;
            cin      = c_q;
         end
         default: res_d = s1_a;
      endcase
      sum = {1'b0, s1_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      if (is_arith) begin
         res_d = sum[WIDTH-1:0];
         c_d   = sum[WIDTH];
         v_d   = (s1_a[WIDTH-1] == b_eff[WIDTH-1]) & (res_d[WIDTH-1] != s1_a[WIDTH-1]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         res_q    <= '0;
         c_out_q  <= 1'b0;
         z_out_q  <= 1'b0;
         n_out_q  <= 1'b0;
         v_out_q  <= 1'b0;
      end else if (adv2) begin
         s2_valid <= 1'b1;
         res_q    <= res_d;
         c_out_q  <= c_d;
         z_out_q  <= (res_d == '0);
         n_out_q  <= res_d[WIDTH-1];
         v_out_q  <= v_d;
      end else if (bus.out_ready) begin
         s2_valid <= 1'b0;
      end
   end

   // A clear coinciding with an arithmetic advance wins; the beat still
   // reports its own carry on the output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q <= 1'b0;
      end else if (bus.carry_clr) begin
         c_q <= 1'b0;
      end else if (adv2 && is_arith) begin
         c_q <= c_d;
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.result    = res_q;
   assign bus.flag_c    = c_out_q;
   assign bus.flag_z    = z_out_q;
   assign bus.flag_n    = n_out_q;
   assign bus.flag_v    = v_out_q;

endmodule

// File: tb/tb_alu_pipe_n.sv
// Self-checking bench for alu_pipe_n: directed corner cases with literal
// expectations, then randomized traffic scored against an arithmetic model.
module tb_alu_pipe_n;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] res;
      logic [3:0]   f;
   } beat_t;

   logic clk;
   logic rst_n;

   alu_pipe_n_if #(.WIDTH(W)) bus ();

   alu_pipe_n #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    checks = 0;
   int    passes = 0;
   int    cycle = 0;
   int    acc_cycle = 0;
   int    n_acc = 0;
   bit    use_model = 0;
   bit    model_c = 0;
   bit    hold_pending = 0;
   beat_t held;
   beat_t expq[$];
   int    out_cycles[$];

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp)
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cycle);
      else
         passes++;
   endtask

   // Reference: plain integer arithmetic on unsigned and signed values.
   function automatic beat_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
      beat_t e;
      int ua, ub, sa, sb, r, sr, cin, borrow;
      logic c, v, arith;
      ua = a; ub = b;
      sa = $signed(a); sb = $signed(b);
      r = 0; c = 0; v = 0; arith = 0;
      case (op)
         3'd0: r = ua & ub;
         3'd1: r = ua | ub;
         3'd4: r = ua ^ ub;
         3'd7: r = ua;
         3'd2, 3'd5: begin
            arith = 1;
            cin = (op == 3'd5) ? int'(model_c) : 0;
            r = ua + ub + cin;
            c = (r > 65535);
            sr = sa + sb + cin;
            v = (sr > 32767) || (sr < -32768);
         end
         default: begin
            arith = 1;
            borrow = (op == 3'd3) ? 0 : (model_c ? 0 : 1);
            r = ua - ub - borrow;
            c = (ua >= ub + borrow);
            sr = sa - sb - borrow;
            v = (sr > 32767) || (sr < -32768);
         end
      endcase
      if (arith) model_c = c;
      e.res = r[W-1:0];
      e.f = {c, (e.res == '0), e.res[W-1], v};
      return e;
   endfunction

   function automatic beat_t mk(input logic [W-1:0] r, input logic c, input logic v);
      beat_t e;
      e.res = r;
      e.f = {c, (r == '0), r[W-1], v};
      return e;
   endfunction

   // One clock: sample just after the negedge drive, score transfers, advance.
   task automatic tick();
      beat_t e;
      #1;
      if (hold_pending) begin
         checkOutput("hold_valid", bus.out_valid, 1);
         checkOutput("hold_result", bus.result, held.res);
         checkOutput("hold_flags", {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, held.f);
      end
      hold_pending = bus.out_valid & ~bus.out_ready;
      held.res = bus.result;
      held.f = {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v};
      if (bus.out_valid && bus.out_ready) begin
         out_cycles.push_back(cycle);
         checkOutput("out_expected", (expq.size() > 0), 1);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput("result", bus.result, e.res);
            checkOutput("flags_czdv", {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, e.f);
         end
      end
      if (bus.in_valid && bus.in_ready) begin
         acc_cycle = cycle;
         n_acc++;
         if (use_model) expq.push_back(model(bus.a, bus.b, bus.op));
      end
      @(negedge clk);
      cycle++;
   endtask

   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
      int start;
      int k;
      start = n_acc;
      bus.in_valid = 1'b1;
      bus.a = a;
      bus.b = b;
      bus.op = op;
      k = 0;
      while (n_acc == start && k < 20) begin
         tick();
         k++;
      end
      checkOutput("accept_timeout", n_acc - start, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (expq.size() > 0 && k < 60) begin
         tick();
         k++;
      end
      checkOutput("drain_left", expq.size(), 0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h7FFF;
         3: return 16'h8000;
         4: return 16'h0001;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int snap;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.op = 3'd0;
      bus.carry_clr = 1'b0;
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_out_valid", bus.out_valid, 0);
      checkOutput("reset_result", bus.result, 0);
      checkOutput("reset_flags", {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_in_ready", bus.in_ready, 1);

      // SUB 5-7 and its latency
      out_cycles.delete();
      expq.push_back(mk(16'hFFFE, 1'b0, 1'b0));
      applyStimulus(16'h0005, 16'h0007, 3'd3);
      drain();
      checkOutput("latency_count", out_cycles.size(), 1);
      if (out_cycles.size() > 0) checkOutput("latency", out_cycles[0] - acc_cycle, 2);

      // wrap-around then back-to-back ADC
      expq.push_back(mk(16'h0000, 1'b1, 1'b0));
      expq.push_back(mk(16'h0001, 1'b0, 1'b0));
      applyStimulus(16'hFFFF, 16'h0001, 3'd2);
      applyStimulus(16'h0000, 16'h0000, 3'd5);
      drain();

      // signed overflow both directions
      expq.push_back(mk(16'h8000, 1'b0, 1'b1));
      expq.push_back(mk(16'h7FFF, 1'b1, 1'b1));
      applyStimulus(16'h7FFF, 16'h0001, 3'd2);
      applyStimulus(16'h8000, 16'h0001, 3'd3);
      drain();

      // stall: two beats held, then release
      for (int i = 0; i < 6; i++)
         expq.push_back(mk((16'h1000 + W'(i)) ^ 16'h0011, 1'b0, 1'b0));
      applyStimulus(16'h1000, 16'h0011, 3'd4);
      applyStimulus(16'h1001, 16'h0011, 3'd4);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.a = 16'h1002;
      bus.b = 16'h0011;
      bus.op = 3'd4;
      snap = n_acc;
      repeat (4) tick();
      checkOutput("stall_in_ready", bus.in_ready, 0);
      checkOutput("stall_no_accept", n_acc - snap, 0);
      out_cycles.delete();
      bus.out_ready = 1'b1;
      for (int i = 2; i < 6; i++)
         applyStimulus(16'h1000 + W'(i), 16'h0011, 3'd4);
      drain();
      checkOutput("release_count", out_cycles.size(), 6);
      if (out_cycles.size() == 6) checkOutput("release_rate", out_cycles[5] - out_cycles[0], 5);

      // carry_clr on the ADD's advance, logic op in between
      expq.push_back(mk(16'h0000, 1'b1, 1'b0));
      expq.push_back(mk(16'h00F0, 1'b0, 1'b0));
      expq.push_back(mk(16'h0002, 1'b0, 1'b0));
      applyStimulus(16'hFFFF, 16'h0001, 3'd2);
      bus.carry_clr = 1'b1;
      tick();
      bus.carry_clr = 1'b0;
      applyStimulus(16'hF0F0, 16'h0FF0, 3'd0);
      applyStimulus(16'h0001, 16'h0001, 3'd5);
      drain();

      // reset with two beats in flight (carry set by the ADD)
      applyStimulus(16'hFFFF, 16'h0001, 3'd2);
      applyStimulus(16'h0001, 16'h0001, 3'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_out_valid", bus.out_valid, 0);
      checkOutput("midreset_result", bus.result, 0);
      hold_pending = 0;
      expq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cycle += 2;
      checkOutput("postreset_in_ready", bus.in_ready, 1);
      expq.push_back(mk(16'h0003, 1'b0, 1'b0));
      applyStimulus(16'h0001, 16'h0002, 3'd5);
      drain();

      // randomized traffic against the model; stored carry is 0 here
      use_model = 1;
      model_c = 0;
      for (int i = 0; i < 500; i++) begin
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.a = pick();
         bus.b = pick();
         bus.op = 3'($urandom_range(0, 7));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
